// File: rtl/stopwatch_lap.sv
// BCD stopwatch with lap freeze, clear, overflow saturation and an active-low 7-segment scan.
// Optional feature: define STOPWATCH_LZB_EN for leading-zero blanking above the decimal point.
module stopwatch_lap #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned TICK_HZ    = 100,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DP_POS     = 2,
    parameter int unsigned SCAN_DIV   = 100_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_stop,
    input  logic                  lap,
    output logic [7:0]            Seg,
    output logic                  decimal,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  running,
    output logic                  overflow
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CW       = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {
        StStopped,
        StRunning,
        StOverflow
    } state_e;

    state_e state_q, state_d;

    logic          ss_prev_q, lap_prev_q;
    logic          ss_edge, lap_edge;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] count_q, count_d, count_inc;
    logic [CW-1:0] frz_q, frz_d;
    logic          frozen_q, frozen_d;
    logic          tick, all9, clear;
    logic [SW-1:0] scan_q, scan_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] disp;
    logic [3:0]    cur_digit;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic          running_q, running_d;
    logic          overflow_q, overflow_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign ss_edge  = start_stop & ~ss_prev_q;
    assign lap_edge = lap & ~lap_prev_q;
    assign tick     = (state_q == StRunning) && (presc_q == PW'(TICK_DIV - 1));
    // Lap acts as a clear whenever the watch was not running before this cycle's edges.
    assign clear    = lap_edge && (state_q != StRunning);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StStopped;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; saturation takes priority over a coincident stop edge
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StStopped: begin
                if (ss_edge) state_d = StRunning;
            end
            StRunning: begin
                if (tick && all9) begin
                    state_d = StOverflow;
                end else if (ss_edge) begin
                    state_d = StStopped;
                end
            end
            StOverflow: begin
                if (lap_edge) state_d = StStopped;
            end
            default: state_d = StStopped;
        endcase
    end

    // FSM outputs, registered alongside the state
    always_comb begin
        running_d  = (state_d == StRunning);
        overflow_d = (state_d == StOverflow);
    end

    always_comb begin
        logic carry;
        carry     = 1'b1;
        all9      = 1'b1;
        count_inc = count_q;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            all9 = all9 && (count_q[4*i +: 4] == 4'd9);
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_comb begin
        presc_d  = presc_q;
        count_d  = count_q;
        frozen_d = frozen_q;
        frz_d    = frz_q;
        if (clear) begin
            presc_d  = '0;
            count_d  = '0;
            frozen_d = 1'b0;
        end else begin
            if (state_q == StRunning) begin
                presc_d = tick ? '0 : presc_q + 1'b1;
            end
            if (tick && !all9) begin
                count_d = count_inc;
            end
            if (lap_edge && (state_q == StRunning)) begin
                frozen_d = ~frozen_q;
                if (!frozen_q) frz_d = count_q;
            end
        end
    end

    always_comb begin
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SW'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    assign disp = frozen_q ? frz_q : count_q;

`ifdef STOPWATCH_LZB_EN
    logic [NUM_DIGITS-1:0] blank;
    logic                  cur_blank;

    // A digit is blank when it and every digit above it are zero, never at or below the point.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        blank      = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (disp[4*i +: 4] == 4'd0);
            blank[i]   = upper_zero && (i > int'(DP_POS));
        end
    end
`endif

    always_comb begin
        cur_digit = 4'd0;
`ifdef STOPWATCH_LZB_EN
        cur_blank = 1'b0;
`endif
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IW'(i)) begin
                cur_digit = disp[4*i +: 4];
`ifdef STOPWATCH_LZB_EN
                cur_blank = blank[i];
`endif
            end
        end
`ifdef STOPWATCH_LZB_EN
        seg_d = cur_blank ? 7'h7F : seg_decode(cur_digit);
`else
        seg_d = seg_decode(cur_digit);
`endif
        dp_d = (idx_q != IW'(DP_POS));
        an_d = ~(NUM_DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ss_prev_q  <= 1'b0;
            lap_prev_q <= 1'b0;
            presc_q    <= '0;
            count_q    <= '0;
            frz_q      <= '0;
            frozen_q   <= 1'b0;
            scan_q     <= '0;
            idx_q      <= '0;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            an_q       <= '1;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            ss_prev_q  <= start_stop;
            lap_prev_q <= lap;
            presc_q    <= presc_d;
            count_q    <= count_d;
            frz_q      <= frz_d;
            frozen_q   <= frozen_d;
            scan_q     <= scan_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            running_q  <= running_d;
            overflow_q <= overflow_d;
        end
    end

    assign Seg      = {dp_q, seg_q};
    assign decimal  = dp_q;
    assign an       = an_q;
    assign running  = running_q;
    assign overflow = overflow_q;

endmodule
